// File: rtl/arb3_rr_ctrl_pkg.sv
// Shared definitions for the three-requester round-robin arbiter: state encoding,
// requester count, default watchdog length and the one-hot grant helper.
package arb3_rr_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StHold = 2'b01,
        StGap  = 2'b10
    } arb_state_e;

    localparam int unsigned ArbN     = 3;
    localparam int unsigned DefToCyc = 15;

    // Pointer resets to 2 so requester 0 is scanned first.
    localparam logic [1:0] PtrRst = 2'd2;

    function automatic logic [ArbN-1:0] onehot3(input logic [1:0] idx);
        logic [ArbN-1:0] oh;
        oh = '0;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/arb3_rr_ctrl_rr_pick3.sv
// Combinational rotate-priority picker: first set request after ptr, scanning modulo 3.
// Written as NOR/NAND terms so it maps directly onto the discrete gate set.
module rr_pick3
    import arb3_rr_ctrl_pkg::*;
(
    input  logic [ArbN-1:0] req,
    input  logic [1:0]      ptr,
    output logic [1:0]      pick,
    output logic            valid
);

    logic s0, s1, s2;
    logic nor12, nor20, nor01;
    logic a0_0, a0_1, a1_0, a1_1, a2_0, a2_1;
    logic en0, en1, en2;
    logic g0, g1, g2;

    // ptr == 3 is unreachable and decodes like ptr == 2.
    assign s2 = ptr[1];
    assign s0 = ~(ptr[1] | ptr[0]);
    assign s1 = ~(ptr[1] | ~ptr[0]);

    assign nor12 = ~(req[1] | req[2]);
    assign nor20 = ~(req[2] | req[0]);
    assign nor01 = ~(req[0] | req[1]);

    assign a0_0 = ~(s0 & nor12);
    assign a0_1 = ~(s1 & ~req[2]);
    assign en0  = ~(~s2 & a0_0 & a0_1);

    assign a1_0 = ~(s2 & ~req[0]);
    assign a1_1 = ~(s1 & nor20);
    assign en1  = ~(~s0 & a1_0 & a1_1);

    assign a2_0 = ~(s0 & ~req[1]);
    assign a2_1 = ~(s2 & nor01);
    assign en2  = ~(~s1 & a2_0 & a2_1);

    assign g0 = req[0] & en0;
    assign g1 = req[1] & en1;
    assign g2 = req[2] & en2;

    assign pick  = {g2, g1};
    assign valid = ~(~req[0] & ~req[1] & ~req[2]);

    logic unused_g0;
    assign unused_g0 = g0;

endmodule

// File: rtl/arb3_rr_ctrl.sv
// Round-robin arbiter for one shared single-owner resource. The grant is held until the
// owner finishes, drops its request or the watchdog expires, followed by one turnaround cycle.
module arb3_rr_ctrl
    import arb3_rr_ctrl_pkg::*;
#(
    parameter int unsigned TO_W   = 4,
    parameter int unsigned TO_CYC = DefToCyc,
    parameter int unsigned TO_EN  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ArbN-1:0] req,
    input  logic [ArbN-1:0] done,
    output logic [ArbN-1:0] gnt,
    output logic            busy,
    output logic            tmo,
    output logic [1:0]      tmo_id
);

    localparam logic [TO_W-1:0] CntMax  = '1;
    localparam logic [TO_W-1:0] CntLast = TO_W'(TO_CYC - 1);

    arb_state_e      state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [ArbN-1:0] gnt_q, gnt_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            tmo_q, tmo_d;
    logic [1:0]      tmo_id_q, tmo_id_d;

    logic [1:0] pick;
    logic       pick_valid;
    logic       owner_done, owner_req, expire;

    rr_pick3 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .pick  (pick),
        .valid (pick_valid)
    );

    // Masking with the grant ignores DONE/REQ from everyone but the owner.
    assign owner_done = |(done & gnt_q);
    assign owner_req  = |(req & gnt_q);
    assign expire     = (TO_EN != 0) && (cnt_q == CntLast);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        tmo_d    = 1'b0;
        tmo_id_d = tmo_id_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    gnt_d   = onehot3(pick);
                    ptr_d   = pick;
                    cnt_d   = '0;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (owner_done || !owner_req || expire) begin
                    gnt_d   = '0;
                    state_d = StGap;
                    // A normal release in the expiry cycle takes precedence over the watchdog.
                    if (!owner_done && owner_req) begin
                        tmo_d    = 1'b1;
                        tmo_id_d = ptr_q;
                    end
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            ptr_q    <= PtrRst;
            gnt_q    <= '0;
            cnt_q    <= '0;
            tmo_q    <= 1'b0;
            tmo_id_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            tmo_id_q <= tmo_id_d;
        end
    end

    assign gnt    = gnt_q;
    assign busy   = |gnt_q;
    assign tmo    = tmo_q;
    assign tmo_id = tmo_id_q;

endmodule

// File: tb/tb_arb3_rr_ctrl.sv
// Self-checking bench for arb3_rr_ctrl: directed scenarios plus random traffic, all
// checked against a behavioural owner/turn model kept in the bench.
module tb_arb3_rr_ctrl;

    localparam int unsigned TO_W   = 4;
    localparam int unsigned TO_CYC = 15;
    localparam int unsigned TO_EN  = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req = 3'b000;
    logic [2:0] done = 3'b000;
    logic [2:0] gnt;
    logic       busy;
    logic       tmo;
    logic [1:0] tmo_id;
    logic [6:0] obs;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: who owns the resource, how long, whose turn was last.
    int m_owner;
    int m_held;
    int m_last;
    int m_tmo_id;
    bit m_gap;
    bit m_tmo;

    arb3_rr_ctrl #(
        .TO_W   (TO_W),
        .TO_CYC (TO_CYC),
        .TO_EN  (TO_EN)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .done   (done),
        .gnt    (gnt),
        .busy   (busy),
        .tmo    (tmo),
        .tmo_id (tmo_id)
    );

    always #5 clk = ~clk;

    assign obs = {gnt, busy, tmo, tmo_id};

    function automatic void model_reset();
        m_owner  = -1;
        m_held   = 0;
        m_last   = 2;
        m_tmo_id = 0;
        m_gap    = 1'b0;
        m_tmo    = 1'b0;
    endfunction

    function automatic void model_step(input logic [2:0] r, input logic [2:0] d);
        bit t;
        bit fin;
        bit found;
        int idx;
        t = 1'b0;
        found = 1'b0;
        if (m_owner >= 0) begin
            fin = d[m_owner] || !r[m_owner];
            if (fin || (TO_EN != 0 && m_held == int'(TO_CYC) - 1)) begin
                if (!fin) begin
                    t = 1'b1;
                    m_tmo_id = m_owner;
                end
                m_owner = -1;
                m_gap = 1'b1;
            end else begin
                m_held++;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else begin
            for (int k = 1; k <= 3; k++) begin
                idx = (m_last + k) % 3;
                if (!found && r[idx]) begin
                    found = 1'b1;
                    m_owner = idx;
                    m_last = idx;
                    m_held = 0;
                end
            end
        end
        m_tmo = t;
    endfunction

    function automatic logic [2:0] exp_gnt();
        return (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
    endfunction

    function automatic logic [6:0] exp_obs();
        return {exp_gnt(), (m_owner >= 0), m_tmo, 2'(m_tmo_id)};
    endfunction

    task automatic tick(input logic [2:0] r, input logic [2:0] d);
        @(negedge clk);
        req  = r;
        done = d;
        model_step(r, d);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        req  = 3'b000;
        done = 3'b000;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 3'b111;
        model_reset();
        #3;
        vectors++;
        if (obs !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_async got %b want %b", obs, 7'd0);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (obs !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_held got %b want %b", obs, 7'd0);
        end
    endtask

    task automatic test_rotation();
        logic [2:0] d;
        logic [2:0] prev;
        logic [2:0] want [4];
        logic [2:0] grants[$];
        int gaps[$];
        int zrun;
        want = '{3'b001, 3'b010, 3'b100, 3'b001};
        prev = 3'b000;
        zrun = 0;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            d = (m_owner >= 0 && m_held == 1) ? exp_gnt() : 3'b000;
            tick(3'b111, d);
            vectors++;
            if (obs !== exp_obs()) begin
                miscompares++;
                $display("FAIL rotation c=%0d got %b want %b", c, obs, exp_obs());
            end
            if (gnt == 3'b000) begin
                zrun++;
            end else if (prev == 3'b000) begin
                grants.push_back(gnt);
                gaps.push_back(zrun);
                zrun = 0;
            end
            prev = gnt;
        end
        vectors++;
        if (grants.size() < 4) begin
            miscompares++;
            $display("FAIL rotation_count got %0d grants want >=4", grants.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (grants[i] !== want[i]) begin
                    miscompares++;
                    $display("FAIL rotation_seq i=%0d got %b want %b", i, grants[i], want[i]);
                end
                if (i > 0) begin
                    vectors++;
                    if (gaps[i] != 2) begin
                        miscompares++;
                        $display("FAIL rotation_gap i=%0d got %0d want 2", i, gaps[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_single();
        logic [2:0] d;
        logic [2:0] first;
        first = 3'b000;
        do_reset();
        tick(3'b010, 3'b000);
        vectors++;
        if (gnt !== 3'b010) begin
            miscompares++;
            $display("FAIL single_latency got %b want 010", gnt);
        end
        for (int c = 0; c < 3; c++) begin
            d = (m_owner == 1 && m_held == 2) ? 3'b010 : 3'b000;
            tick(3'b010, d);
            vectors++;
            if (obs !== exp_obs()) begin
                miscompares++;
                $display("FAIL single c=%0d got %b want %b", c, obs, exp_obs());
            end
        end
        vectors++;
        if (gnt !== 3'b000) begin
            miscompares++;
            $display("FAIL single_release got %b want 000", gnt);
        end
        for (int c = 0; c < 6; c++) begin
            tick(3'b011, 3'b000);
            vectors++;
            if (obs !== exp_obs()) begin
                miscompares++;
                $display("FAIL single_rot c=%0d got %b want %b", c, obs, exp_obs());
            end
            if (first == 3'b000) first = gnt;
        end
        vectors++;
        if (first !== 3'b001) begin
            miscompares++;
            $display("FAIL single_next got %b want 001", first);
        end
    endtask

    task automatic test_watchdog();
        int held;
        int tmos;
        bit regrant;
        held = 0;
        tmos = 0;
        regrant = 1'b0;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            tick(3'b100, 3'b000);
            vectors++;
            if (obs !== exp_obs()) begin
                miscompares++;
                $display("FAIL watchdog c=%0d got %b want %b", c, obs, exp_obs());
            end
            if (tmo) begin
                tmos++;
                vectors++;
                if (tmo_id !== 2'd2) begin
                    miscompares++;
                    $display("FAIL watchdog_id got %0d want 2", tmo_id);
                end
            end
            if (gnt == 3'b100 && tmos == 0) held++;
            if (gnt == 3'b100 && tmos > 0) regrant = 1'b1;
        end
        vectors++;
        if (held != 15 || tmos != 1 || !regrant) begin
            miscompares++;
            $display("FAIL watchdog_sum got held=%0d tmo=%0d regrant=%0d want 15 1 1",
                     held, tmos, regrant);
        end
    endtask

    task automatic test_foreign_done();
        logic [2:0] dv [4];
        dv = '{3'b000, 3'b010, 3'b100, 3'b110};
        do_reset();
        for (int c = 0; c < 4; c++) begin
            tick(3'b001, dv[c]);
            vectors++;
            if (obs !== exp_obs() || gnt !== 3'b001) begin
                miscompares++;
                $display("FAIL foreign c=%0d got %b want %b", c, obs, exp_obs());
            end
        end
        for (int c = 0; c < 2; c++) begin
            tick(3'b000, 3'b000);
            vectors++;
            if (obs !== exp_obs() || gnt !== 3'b000 || tmo !== 1'b0) begin
                miscompares++;
                $display("FAIL foreign_drop c=%0d got %b want %b", c, obs, exp_obs());
            end
        end
    endtask

    task automatic test_coincident();
        bit seen_tmo;
        seen_tmo = 1'b0;
        do_reset();
        for (int c = 0; c < 20 && !(m_owner == 2 && m_held == int'(TO_CYC) - 1); c++) begin
            tick(3'b100, 3'b000);
            vectors++;
            if (obs !== exp_obs()) begin
                miscompares++;
                $display("FAIL coinc_hold c=%0d got %b want %b", c, obs, exp_obs());
            end
        end
        tick(3'b100, 3'b100);
        if (tmo) seen_tmo = 1'b1;
        vectors++;
        if (obs !== exp_obs() || gnt !== 3'b000) begin
            miscompares++;
            $display("FAIL coinc_rel got %b want %b", obs, exp_obs());
        end
        tick(3'b000, 3'b111);
        if (tmo) seen_tmo = 1'b1;
        vectors++;
        if (obs !== exp_obs()) begin
            miscompares++;
            $display("FAIL coinc_idle got %b want %b", obs, exp_obs());
        end
        vectors++;
        if (seen_tmo) begin
            miscompares++;
            $display("FAIL coinc_tmo got 1 want 0");
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(3'b111, 3'b000);
        tick(3'b111, 3'b000);
        vectors++;
        if (obs !== exp_obs()) begin
            miscompares++;
            $display("FAIL areset_pre got %b want %b", obs, exp_obs());
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (gnt !== 3'b000 || busy !== 1'b0 || tmo !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_async got %b want 0000 0 0", {gnt, busy, tmo});
        end
        @(posedge clk);
        #1;
        vectors++;
        if (tmo !== 1'b0 || gnt !== 3'b000) begin
            miscompares++;
            $display("FAIL areset_tmo got gnt=%b tmo=%b want 000 0", gnt, tmo);
        end
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        tick(3'b111, 3'b000);
        vectors++;
        if (obs !== exp_obs() || gnt !== 3'b001) begin
            miscompares++;
            $display("FAIL areset_first got %b want %b", obs, exp_obs());
        end
    endtask

    task automatic test_random();
        logic [2:0] r;
        logic [2:0] d;
        r = 3'b000;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
            d = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            tick(r, d);
            vectors++;
            if (obs !== exp_obs() || $countones(gnt) > 1) begin
                miscompares++;
                $display("FAIL random c=%0d r=%b d=%b got %b want %b", c, r, d, obs, exp_obs());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rotation();
        test_single();
        test_watchdog();
        test_foreign_done();
        test_coincident();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
